// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle ripple-borrow subtractor, SLICE bits per clock.
// Computes d = x - y - bin over WIDTH bits with a start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("serial_subtractor: SLICE must divide WIDTH");
   end

   logic [0:0]       state_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] part_q;
   logic             brw_q;
   logic [IW-1:0]    idx_q;

   logic [SLICE-1:0] xs;
   logic [SLICE-1:0] ys;
   logic [SLICE-1:0] ds;
   logic             brw_nxt;
   logic [WIDTH-1:0] res;
   logic             last;
   int unsigned      base;

   // One slice of ripple subtract; res is the partial with this slice merged in
   always_comb begin
      base = 32'(idx_q) * 32'(SLICE);
      xs   = x_q[base +: SLICE];
      ys   = y_q[base +: SLICE];
      {brw_nxt, ds} = {1'b0, xs} - {1'b0, ys} - {{SLICE{1'b0}}, brw_q};
      res  = part_q;
      res[base +: SLICE] = ds;
      last = (idx_q == IW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         part_q  <= '0;
         brw_q   <= 1'b0;
         idx_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         d       <= '0;
         b       <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (1'b1)
            (state_q == IDLE): begin
               if (start) begin
                  x_q     <= x;
                  y_q     <= y;
                  brw_q   <= bin;
                  idx_q   <= '0;
                  part_q  <= '0;
                  busy    <= 1'b1;
                  state_q <= RUN;
               end
            end
            (state_q == RUN): begin
               part_q <= res;
               brw_q  <= brw_nxt;
               idx_q  <= idx_q + 1'b1;
               if (last) begin
                  d       <= res;
                  b       <= brw_nxt;
                  ovf     <= (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                             (res[WIDTH-1] != x_q[WIDTH-1]);
                  zero    <= ~|res;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  idx_q   <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench for three configurations
// (8/1, 8/4, 1/1) against an arithmetic reference model.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] d;
      logic       b;
      logic       ovf;
      logic       zero;
      int         acc;
      int         n;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic       start_a = 0, bin_a = 0;
   logic [7:0] x_a = 0, y_a = 0, d_a;
   logic       busy_a, done_a, b_a, ovf_a, zero_a;

   logic       start_c = 0, bin_c = 0;
   logic [7:0] x_c = 0, y_c = 0, d_c;
   logic       busy_c, done_c, b_c, ovf_c, zero_c;

   logic       start_e = 0, bin_e = 0;
   logic [0:0] x_e = 0, y_e = 0, d_e;
   logic       busy_e, done_e, b_e, ovf_e, zero_e;

   exp_t qa[$];
   exp_t qc[$];
   exp_t qe[$];

   serial_subtractor #(.WIDTH(8), .SLICE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .x(x_a), .y(y_a),
      .bin(bin_a), .busy(busy_a), .done(done_a), .d(d_a), .b(b_a),
      .ovf(ovf_a), .zero(zero_a));

   serial_subtractor #(.WIDTH(8), .SLICE(4)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .x(x_c), .y(y_c),
      .bin(bin_c), .busy(busy_c), .done(done_c), .d(d_c), .b(b_c),
      .ovf(ovf_c), .zero(zero_c));

   serial_subtractor #(.WIDTH(1), .SLICE(1)) u_e (
      .clk(clk), .rst_n(rst_n), .start(start_e), .x(x_e), .y(y_e),
      .bin(bin_e), .busy(busy_e), .done(done_e), .d(d_e), .b(b_e),
      .ovf(ovf_e), .zero(zero_e));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(int w, logic [7:0] xv, logic [7:0] yv,
                                  logic bv, int acc, int n);
      exp_t r;
      int   diff;
      int   msb;
      diff   = int'(xv) - int'(yv) - int'(bv);
      msb    = w - 1;
      r.d    = 8'(diff & ((1 << w) - 1));
      r.b    = (diff < 0);
      r.ovf  = (xv[msb] != yv[msb]) && (r.d[msb] != xv[msb]);
      r.zero = (r.d == 8'd0);
      r.acc  = acc;
      r.n    = n;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_res(string tg, exp_t e, logic [7:0] dv, logic bv,
                          logic ov, logic zv);
      chk({tg, "_d"}, 32'(dv), 32'(e.d));
      chk({tg, "_b"}, 32'(bv), 32'(e.b));
      chk({tg, "_ovf"}, 32'(ov), 32'(e.ovf));
      chk({tg, "_zero"}, 32'(zv), 32'(e.zero));
      chk({tg, "_latency"}, 32'(cyc - e.acc), 32'(e.n));
   endtask

   task automatic spurious(string tg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unexpected_done at cycle %0d", tg, cyc);
   endtask

   always @(negedge clk) begin
      if (rst_n && done_a) begin
         if (qa.size() == 0) spurious("a");
         else chk_res("a", qa.pop_front(), d_a, b_a, ovf_a, zero_a);
      end
   end

   always @(negedge clk) begin
      if (rst_n && done_c) begin
         if (qc.size() == 0) spurious("c");
         else chk_res("c", qc.pop_front(), d_c, b_c, ovf_c, zero_c);
      end
   end

   always @(negedge clk) begin
      if (rst_n && done_e) begin
         if (qe.size() == 0) spurious("e");
         else chk_res("e", qe.pop_front(), {7'd0, d_e}, b_e, ovf_e, zero_e);
      end
   end

   function automatic logic busy_of(int sel);
      if (sel == 0) return busy_a;
      if (sel == 1) return busy_c;
      return busy_e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(int sel, logic [7:0] xv, logic [7:0] yv, logic bv);
      int k = 0;
      while (busy_of(sel) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy_of(sel)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL issue_timeout sel %0d busy %0d", sel, busy_of(sel));
         return;
      end
      case (sel)
         0: begin
            x_a = xv; y_a = yv; bin_a = bv; start_a = 1'b1;
            qa.push_back(model(8, xv, yv, bv, cyc + 1, 8));
         end
         1: begin
            x_c = xv; y_c = yv; bin_c = bv; start_c = 1'b1;
            qc.push_back(model(8, xv, yv, bv, cyc + 1, 2));
         end
         default: begin
            x_e = xv[0]; y_e = yv[0]; bin_e = bv; start_e = 1'b1;
            qe.push_back(model(1, {7'd0, xv[0]}, {7'd0, yv[0]}, bv,
                               cyc + 1, 1));
         end
      endcase
      @(negedge clk);
      start_a = 1'b0;
      start_c = 1'b0;
      start_e = 1'b0;
      // Operand changes while running must not matter
      x_a = 8'($urandom); y_a = 8'($urandom); bin_a = 1'($urandom);
      x_c = 8'($urandom); y_c = 8'($urandom); bin_c = 1'($urandom);
   endtask

   task automatic chk_cleared(string tg);
      chk({tg, "_busy"}, 32'(busy_a), 32'd0);
      chk({tg, "_done"}, 32'(done_a), 32'd0);
      chk({tg, "_d"}, 32'(d_a), 32'd0);
      chk({tg, "_b"}, 32'(b_a), 32'd0);
      chk({tg, "_ovf"}, 32'(ovf_a), 32'd0);
      chk({tg, "_zero"}, 32'(zero_a), 32'd0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_cleared("reset");
      chk("reset_c_busy", 32'(busy_c), 32'd0);
      chk("reset_e_done", 32'(done_e), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(0, 8'h35, 8'h12, 1'b0);
      issue(0, 8'h00, 8'h01, 1'b0);
      issue(0, 8'h80, 8'h01, 1'b0);
      issue(0, 8'h05, 8'h05, 1'b0);
      issue(0, 8'h05, 8'h05, 1'b1);

      issue(0, 8'h5A, 8'h3C, 1'b0);
      repeat (2) @(negedge clk);
      x_a = 8'hFF; y_a = 8'h00; bin_a = 1'b1; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;

      for (int i = 0; i < 40; i++)
         issue(0, 8'($urandom), 8'($urandom), 1'($urandom));

      issue(0, 8'h77, 8'h11, 1'b0);
      repeat (3) @(negedge clk);
      qa.delete();
      rst_n = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      start_a = 1'b0;
      chk_cleared("abort");
      repeat (12) @(negedge clk);
      chk("abort_idle_busy", 32'(busy_a), 32'd0);
      chk("abort_hold_d", 32'(d_a), 32'd0);

      issue(0, 8'h01, 8'h02, 1'b0);
      issue(1, 8'h10, 8'h01, 1'b0);
      for (int i = 0; i < 25; i++)
         issue(1, 8'($urandom), 8'($urandom), 1'($urandom));

      for (int i = 0; i < 8; i++) begin
         logic [2:0] c;
         c = 3'(i);
         issue(2, {7'd0, c[2]}, {7'd0, c[1]}, c[0]);
      end
      for (int i = 0; i < 10; i++)
         issue(2, 8'($urandom), 8'($urandom), 1'($urandom));

      k = 0;
      while ((qa.size() + qc.size() + qe.size()) != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain_a", 32'(qa.size()), 32'd0);
      chk("drain_c", 32'(qc.size()), 32'd0);
      chk("drain_e", 32'(qe.size()), 32'd0);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
